// File: rtl/alu_reservation_station.sv
// Reservation station feeding the ALU: buffers dispatched ops,
// snoops both CDBs, issues one ready op per cycle.
module alu_reservation_station #(
  parameter int RS_SIZE   = 16,
  parameter int ROB_WIDTH = 4
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 rdy_in,
  input  logic                 rollback,
  output logic                 rs_full,
  input  logic                 disp_valid,
  input  logic [6:0]           disp_opcode,
  input  logic [31:0]          disp_op,
  input  logic [31:0]          disp_vj,
  input  logic                 disp_qj_busy,
  input  logic [ROB_WIDTH-1:0] disp_qj,
  input  logic [31:0]          disp_vk,
  input  logic                 disp_qk_busy,
  input  logic [ROB_WIDTH-1:0] disp_qk,
  input  logic [31:0]          disp_pc,
  input  logic [31:0]          disp_imm,
  input  logic [ROB_WIDTH-1:0] disp_dest,
  input  logic                 alu_cdb_valid,
  input  logic [ROB_WIDTH-1:0] alu_cdb_tag,
  input  logic [31:0]          alu_cdb_value,
  input  logic                 lsb_cdb_valid,
  input  logic [ROB_WIDTH-1:0] lsb_cdb_tag,
  input  logic [31:0]          lsb_cdb_value,
  output logic                 alu_valid,
  output logic [6:0]           alu_opcode,
  output logic [31:0]          alu_op,
  output logic [31:0]          alu_vj,
  output logic [31:0]          alu_vk,
  output logic [31:0]          alu_pc,
  output logic [31:0]          alu_imm,
  output logic [ROB_WIDTH-1:0] alu_dest
);

  localparam int IW = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;

  typedef struct packed {
    logic                 busy;
    logic [6:0]           opcode;
    logic [31:0]          op;
    logic [31:0]          vj;
    logic                 qj_busy;
    logic [ROB_WIDTH-1:0] qj;
    logic [31:0]          vk;
    logic                 qk_busy;
    logic [ROB_WIDTH-1:0] qk;
    logic [31:0]          pc;
    logic [31:0]          imm;
    logic [ROB_WIDTH-1:0] dest;
  } ent_t;

  ent_t ent   [RS_SIZE];
  ent_t ent_n [RS_SIZE];

  logic [RS_SIZE-1:0] busy_vec;
  logic [RS_SIZE-1:0] ready_vec;
  logic [IW-1:0]      free_idx;
  logic [IW-1:0]      issue_idx;
  logic               issue_ok;
  logic               disp_ok;

  // Returns {still_pending, value}; ALU CDB wins a tie.
  function automatic logic [32:0] snoop(
    input logic                 b,
    input logic [ROB_WIDTH-1:0] q,
    input logic [31:0]          v,
    input logic                 av,
    input logic [ROB_WIDTH-1:0] at,
    input logic [31:0]          ad,
    input logic                 lv,
    input logic [ROB_WIDTH-1:0] lt,
    input logic [31:0]          ld
  );
    if (b && av && (at == q)) return {1'b0, ad};
    if (b && lv && (lt == q)) return {1'b0, ld};
    return {b, v};
  endfunction

  // Per-entry status vectors from start-of-cycle state.
  always_comb begin
    for (int i = 0; i < RS_SIZE; i++) begin
      busy_vec[i]  = ent[i].busy;
      ready_vec[i] = ent[i].busy && !ent[i].qj_busy
                     && !ent[i].qk_busy;
    end
  end

  assign rs_full = &busy_vec;
  assign disp_ok = disp_valid && !rs_full;

  // Lowest-index free slot and lowest-index ready slot.
  always_comb begin
    free_idx  = '0;
    issue_idx = '0;
    issue_ok  = 1'b0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (!busy_vec[i]) free_idx = IW'(i);
      if (ready_vec[i]) begin
        issue_ok  = 1'b1;
        issue_idx = IW'(i);
      end
    end
  end

  // Next entry state: wakeup, issue release, dispatch insert.
  always_comb begin
    ent_n = ent;
    for (int i = 0; i < RS_SIZE; i++) begin
      if (ent[i].busy) begin
        {ent_n[i].qj_busy, ent_n[i].vj} = snoop(
          ent[i].qj_busy, ent[i].qj, ent[i].vj,
          alu_cdb_valid, alu_cdb_tag, alu_cdb_value,
          lsb_cdb_valid, lsb_cdb_tag, lsb_cdb_value);
        {ent_n[i].qk_busy, ent_n[i].vk} = snoop(
          ent[i].qk_busy, ent[i].qk, ent[i].vk,
          alu_cdb_valid, alu_cdb_tag, alu_cdb_value,
          lsb_cdb_valid, lsb_cdb_tag, lsb_cdb_value);
      end
    end
    if (issue_ok) ent_n[issue_idx].busy = 1'b0;
    if (disp_ok) begin
      ent_n[free_idx].busy   = 1'b1;
      ent_n[free_idx].opcode = disp_opcode;
      ent_n[free_idx].op     = disp_op;
      ent_n[free_idx].qj     = disp_qj;
      ent_n[free_idx].qk     = disp_qk;
      ent_n[free_idx].pc     = disp_pc;
      ent_n[free_idx].imm    = disp_imm;
      ent_n[free_idx].dest   = disp_dest;
      {ent_n[free_idx].qj_busy, ent_n[free_idx].vj} = snoop(
        disp_qj_busy, disp_qj, disp_vj,
        alu_cdb_valid, alu_cdb_tag, alu_cdb_value,
        lsb_cdb_valid, lsb_cdb_tag, lsb_cdb_value);
      {ent_n[free_idx].qk_busy, ent_n[free_idx].vk} = snoop(
        disp_qk_busy, disp_qk, disp_vk,
        alu_cdb_valid, alu_cdb_tag, alu_cdb_value,
        lsb_cdb_valid, lsb_cdb_tag, lsb_cdb_value);
    end
  end

  // Entry storage; freeze on !rdy_in, flush on rollback.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int i = 0; i < RS_SIZE; i++) ent[i] <= '0;
    end else if (rdy_in) begin
      if (rollback) begin
        for (int i = 0; i < RS_SIZE; i++) ent[i].busy <= 1'b0;
      end else begin
        for (int i = 0; i < RS_SIZE; i++) ent[i] <= ent_n[i];
      end
    end
  end

  // Registered issue bundle; data holds when nothing issues.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      alu_valid  <= 1'b0;
      alu_opcode <= '0;
      alu_op     <= '0;
      alu_vj     <= '0;
      alu_vk     <= '0;
      alu_pc     <= '0;
      alu_imm    <= '0;
      alu_dest   <= '0;
    end else if (rdy_in) begin
      if (rollback) begin
        alu_valid <= 1'b0;
      end else begin
        alu_valid <= issue_ok;
        if (issue_ok) begin
          alu_opcode <= ent[issue_idx].opcode;
          alu_op     <= ent[issue_idx].op;
          alu_vj     <= ent[issue_idx].vj;
          alu_vk     <= ent[issue_idx].vk;
          alu_pc     <= ent[issue_idx].pc;
          alu_imm    <= ent[issue_idx].imm;
          alu_dest   <= ent[issue_idx].dest;
        end
      end
    end
  end

endmodule

// File: doc/alu_reservation_station.md
Name: alu_reservation_station

Overview:
Tomasulo reservation station that sits directly upstream of the ALU. It buffers dispatched integer, branch, jump and U-type instructions, and snoops the two CDBs (ALU and LSB) for pending source operands. Each cycle it issues at most one ready instruction to the ALU as a registered operand bundle. The ROB tag travels with each issued instruction, so the ALU result can be broadcast on the CDB.

Parameters:
RS_SIZE, 16, number of entries (2..32)
ROB_WIDTH, 4, width of a ROB tag / dependency tag

Ports:
clk_in  input  1  system clock
rst_in  input  1  synchronous active-high reset
rdy_in  input  1  global ready; low freezes the block
rollback  input  1  misprediction flush; clears all entries
rs_full  output  1  no free entry (combinational from current state)
disp_valid  input  1  dispatcher presents an instruction
disp_opcode  input  7  instruction[6:0]
disp_op  input  32  raw instruction word
disp_vj  input  32  rs1 value (valid when disp_qj_busy=0)
disp_qj_busy  input  1  rs1 pending
disp_qj  input  ROB_WIDTH  rs1 producer tag
disp_vk  input  32  rs2 value
disp_qk_busy  input  1  rs2 pending
disp_qk  input  ROB_WIDTH  rs2 producer tag
disp_pc  input  32  instruction PC
disp_imm  input  32  sign-extended immediate
disp_dest  input  ROB_WIDTH  destination ROB tag
alu_cdb_valid  input  1  ALU CDB broadcast
alu_cdb_tag  input  ROB_WIDTH  ALU CDB tag
alu_cdb_value  input  32  ALU CDB value
lsb_cdb_valid  input  1  LSB CDB broadcast
lsb_cdb_tag  input  ROB_WIDTH  LSB CDB tag
lsb_cdb_value  input  32  LSB CDB value
alu_valid  output  1  issued bundle valid (one cycle per issue)
alu_opcode  output  7  to ALU opcode
alu_op  output  32  to ALU rs_op
alu_vj  output  32  to ALU rs_vj
alu_vk  output  32  to ALU rs_vk
alu_pc  output  32  to ALU rs_pc
alu_imm  output  32  to ALU rs_imm
alu_dest  output  ROB_WIDTH  ROB tag of issued instruction

Behaviour:
- Priority at each posedge: rst_in > !rdy_in > rollback > normal operation.
- Reset: all entries not busy; alu_valid=0; all alu_* data outputs=0.
- rdy_in low: every register holds, including outputs. The ALU stalls under the same signal, so the held alu_valid is not re-consumed.
- rollback: all entries cleared, alu_valid<=0, and a dispatch in the same cycle is discarded.
- Entry fields: busy, opcode, op, vj, qj_busy, qj, vk, qk_busy, qk, pc, imm, dest.
- rs_full = all entries busy, computed from state at the start of the cycle.
- An entry freed by issue in a given cycle is not reusable until the next cycle.
- Dispatch: when disp_valid && !rs_full, write the lowest-index non-busy entry. disp_valid while rs_full is ignored (dispatcher contract violation; assertion in bench).
- Dispatch bypass: if an operand is pending and either CDB broadcasts its tag in the same cycle, store the CDB value and mark the operand ready.
- Wakeup: every busy entry with a pending operand whose tag matches a valid CDB captures the value and clears its busy bit at that edge.
  - If both CDBs match the same tag, take the ALU CDB (tags are unique; case not expected).
  - Both operands of one entry may wake in the same cycle.
- Issue select: uses start-of-cycle state. Picks the lowest-index entry with busy && !qj_busy && !qk_busy.
  - At the edge: alu_* <= entry fields, alu_valid <= 1, entry busy <= 0.
  - If no entry is ready: alu_valid <= 0 and data outputs hold.
- Latency: an instruction dispatched with both operands ready (sampled at edge k) gives alu_valid=1 after edge k+1.
  - An operand woken at edge k makes the entry issuable at edge k+1.
  - CDB-to-ALU minimum latency is 1 cycle.
- Throughput: one issue per cycle; alu_valid can stay high on consecutive cycles for different entries.
- Simultaneous events: dispatch, wakeup and issue all happen in one cycle on distinct entries.
- Operands unused by an opcode (LUI, AUIPC, JAL, rs2 of I-type) are dispatched not-busy; the block does not decode instructions.

Test Plan:
- Reset with entries loaded (rst_in=1 one cycle) -> rs_full=0, alu_valid=0, no issue follows.
- Dispatch ADD vj=5, vk=7, both ready, dest=3 at edge k -> alu_valid=1 after edge k+1 with alu_vj=5, alu_vk=7, alu_dest=3; alu_valid=0 the next cycle.
- Dispatch with qj_busy, qj=2; two cycles later alu_cdb tag=2 value=0x10 -> issue the cycle after the broadcast with alu_vj=0x10.
- Dispatch with qk=4 while lsb_cdb broadcasts tag 4 value 0xFF in the same cycle -> captured at insertion; issues one cycle later with alu_vk=0xFF.
- Fill all 16 entries with pending operands -> rs_full=1; an extra disp_valid is ignored.
  - Wake entry 9 -> it issues, rs_full drops the following cycle.
  - A new dispatch lands in entry 9.
- Three ready entries plus rdy_in low for 3 cycles mid-stream -> outputs frozen during the stall; afterwards issue resumes in index order.
- rollback asserted with dispatch in the same cycle -> all entries cleared, alu_valid=0, nothing issued.
